// File: rtl/key_input_pkg.sv
// Shared definitions for the calc_int key input device: entry-sequence states
// and default build constants.
package key_input_pkg;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_OPW       = 3;
    localparam int DEF_DB_CYCLES = 1000000;

endpackage

// File: rtl/key_input_dev_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// registered single-cycle pulse on each accepted 0->1 level change.
module btn_debounce #(
    parameter int DB_CYCLES = key_input_pkg::DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synced level disagrees with the accepted one.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
                press_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/key_input_dev.sv
// calc_int input device: debounced Enter/Clear buttons drive an A -> B -> opcode
// capture sequence ending in a one-cycle go pulse.
module key_input_dev #(
    parameter int WIDTH     = key_input_pkg::DEF_WIDTH,
    parameter int OPW       = key_input_pkg::DEF_OPW,
    parameter int DB_CYCLES = key_input_pkg::DEF_DB_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_enter,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [OPW-1:0]   opcode,
    output logic             go,
    output logic [1:0]       stage
);

    import key_input_pkg::*;

    logic             enter_press, clear_press;
    state_t           state_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic [OPW-1:0]   opcode_q;
    logic             go_q;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_enter (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_in (btn_enter),
        .press  (enter_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_in (btn_clear),
        .press  (clear_press)
    );

    // Clear has priority over a coincident Enter press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_A;
            op_a_q   <= '0;
            op_b_q   <= '0;
            opcode_q <= '0;
            go_q     <= 1'b0;
        end else begin
            go_q <= 1'b0;
            if (clear_press) begin
                state_q  <= S_A;
                op_a_q   <= '0;
                op_b_q   <= '0;
                opcode_q <= '0;
            end else if (enter_press) begin
                case (state_q)
                    S_A, S_DONE: begin
                        op_a_q  <= sw;
                        state_q <= S_B;
                    end
                    S_B: begin
                        op_b_q  <= sw;
                        state_q <= S_OP;
                    end
                    S_OP: begin
                        opcode_q <= sw[OPW-1:0];
                        go_q     <= 1'b1;
                        state_q  <= S_DONE;
                    end
                    default: state_q <= S_A;
                endcase
            end
        end
    end

    assign op_a   = op_a_q;
    assign op_b   = op_b_q;
    assign opcode = opcode_q;
    assign go     = go_q;
    assign stage  = state_q;

endmodule

// File: tb/tb_key_input_dev.sv
// Scenario bench for key_input_dev: directed button sequences plus a random
// operation stream, all compared against a sequence-level reference model.
module tb_key_input_dev;

    localparam int WIDTH = 4;
    localparam int OPW   = 3;
    localparam int DB    = 16;
    localparam int SETTLE = DB + 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] sw;
    logic             btn_enter, btn_clear;
    logic [WIDTH-1:0] op_a, op_b;
    logic [OPW-1:0]   opcode;
    logic             go;
    logic [1:0]       stage;

    key_input_dev #(.WIDTH(WIDTH), .OPW(OPW), .DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .op_a      (op_a),
        .op_b      (op_b),
        .opcode    (opcode),
        .go        (go),
        .stage     (stage)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // go observer: total high cycles and number of distinct pulses
    int   go_cycles = 0;
    int   go_pulses = 0;
    logic go_prev   = 1'b0;
    always @(negedge clk) begin
        if (go === 1'b1) go_cycles <= go_cycles + 1;
        if (go === 1'b1 && go_prev !== 1'b1) go_pulses <= go_pulses + 1;
        go_prev <= go;
    end

    // Reference model: where the entry sequence stands and what it holds
    int               m_stage = 0;
    logic [WIDTH-1:0] m_a = '0, m_b = '0;
    logic [OPW-1:0]   m_op = '0;
    int               m_go = 0;

    function automatic void model_enter(input logic [WIDTH-1:0] v);
        if (m_stage == 0 || m_stage == 3) begin
            m_a = v; m_stage = 1;
        end else if (m_stage == 1) begin
            m_b = v; m_stage = 2;
        end else begin
            m_op = v[OPW-1:0]; m_go++; m_stage = 3;
        end
    endfunction

    function automatic void model_clear();
        m_a = '0; m_b = '0; m_op = '0; m_stage = 0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bouncy press and release of the selected buttons, then a full settle
    task automatic press(input logic e, input logic c, input logic [WIDTH-1:0] v);
        sw = v;
        repeat ($urandom_range(0, 3)) begin
            btn_enter = e; btn_clear = c; tick($urandom_range(1, 4));
            btn_enter = 0; btn_clear = 0; tick($urandom_range(1, 4));
        end
        btn_enter = e; btn_clear = c;
        tick(SETTLE);
        repeat ($urandom_range(0, 3)) begin
            btn_enter = 0; btn_clear = 0; tick($urandom_range(1, 4));
            btn_enter = e; btn_clear = c; tick($urandom_range(1, 4));
        end
        btn_enter = 0; btn_clear = 0;
        tick(SETTLE);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sw = '0; btn_enter = 0; btn_clear = 0;
        tick(3);
        n_checks++;
        if ({stage, op_a, op_b, opcode, go} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got stage=%0d a=%0d b=%0d op=%0d go=%b, want all 0",
                     stage, op_a, op_b, opcode, go);
        end
        rst_n = 1'b1;
        tick(3);
        n_checks++;
        if ({stage, op_a, op_b, opcode, go} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got stage=%0d a=%0d b=%0d op=%0d go=%b, want all 0",
                     stage, op_a, op_b, opcode, go);
        end
    endtask

    task automatic test_sequence();
        logic [WIDTH-1:0] vals [3] = '{4'd5, 4'd3, 4'd1};
        for (int i = 0; i < 3; i++) begin
            press(1, 0, vals[i]);
            model_enter(vals[i]);
            n_checks++;
            if ({stage, op_a, op_b, opcode} !== {m_stage[1:0], m_a, m_b, m_op}) begin
                n_fail++;
                $display("FAIL seq_step%0d: got stage=%0d a=%0d b=%0d op=%0d, want stage=%0d a=%0d b=%0d op=%0d",
                         i, stage, op_a, op_b, opcode, m_stage, m_a, m_b, m_op);
            end
        end
        n_checks++;
        if (go_pulses != m_go || go_cycles != m_go) begin
            n_fail++;
            $display("FAIL seq_go: got pulses=%0d cycles=%0d, want %0d one-cycle pulses",
                     go_pulses, go_cycles, m_go);
        end
    endtask

    // Clean edge: capture must appear exactly 2 + DB + 1 edges later
    task automatic test_latency();
        logic [1:0] st0;
        int first;
        st0 = stage; first = -1;
        sw = 4'd6;
        btn_enter = 1'b1;
        for (int k = 1; k <= 2 * DB; k++) begin
            tick(1);
            if (first < 0 && stage !== st0) first = k;
        end
        model_enter(4'd6);
        n_checks++;
        if (first != 2 + DB + 1) begin
            n_fail++;
            $display("FAIL latency: got capture after %0d edges, want %0d", first, 2 + DB + 1);
        end
        btn_enter = 1'b0;
        tick(SETTLE);
        n_checks++;
        if ({stage, op_a, op_b, opcode} !== {m_stage[1:0], m_a, m_b, m_op}) begin
            n_fail++;
            $display("FAIL latency_state: got stage=%0d a=%0d, want stage=%0d a=%0d",
                     stage, op_a, m_stage, m_a);
        end
    endtask

    task automatic test_glitch();
        press(0, 1, '0);
        model_clear();
        sw = 4'd11;
        btn_enter = 1'b1; tick(10);
        btn_enter = 1'b0; tick(SETTLE);
        n_checks++;
        if ({stage, op_a, op_b, opcode} !== {m_stage[1:0], m_a, m_b, m_op}) begin
            n_fail++;
            $display("FAIL glitch: got stage=%0d a=%0d, want stage=%0d a=%0d",
                     stage, op_a, m_stage, m_a);
        end
    endtask

    task automatic test_hold();
        sw = 4'd9;
        btn_enter = 1'b1;
        tick(200);
        model_enter(4'd9);
        n_checks++;
        if ({stage, op_a, op_b} !== {m_stage[1:0], m_a, m_b}) begin
            n_fail++;
            $display("FAIL hold: got stage=%0d a=%0d b=%0d, want stage=%0d a=%0d b=%0d",
                     stage, op_a, op_b, m_stage, m_a, m_b);
        end
        btn_enter = 1'b0;
        tick(SETTLE * 2);
        n_checks++;
        if ({stage, op_a, op_b} !== {m_stage[1:0], m_a, m_b}) begin
            n_fail++;
            $display("FAIL hold_release: got stage=%0d a=%0d b=%0d, want stage=%0d a=%0d b=%0d",
                     stage, op_a, op_b, m_stage, m_a, m_b);
        end
    endtask

    task automatic test_clear();
        int go0;
        press(0, 1, '0); model_clear();
        press(1, 0, 4'd5); model_enter(4'd5);
        press(1, 0, 4'd3); model_enter(4'd3);
        go0 = go_pulses;
        press(0, 1, 4'd7); model_clear();
        n_checks++;
        if ({stage, op_a, op_b, opcode} !== '0 || go_pulses != go0) begin
            n_fail++;
            $display("FAIL clear: got stage=%0d a=%0d b=%0d op=%0d go_pulses=%0d, want zeros and go_pulses=%0d",
                     stage, op_a, op_b, opcode, go_pulses, go0);
        end
    endtask

    task automatic test_simultaneous();
        press(1, 0, 4'd4); model_enter(4'd4);
        press(1, 1, 4'd10); model_clear();
        n_checks++;
        if ({stage, op_a, op_b, opcode} !== {m_stage[1:0], m_a, m_b, m_op}) begin
            n_fail++;
            $display("FAIL simultaneous: got stage=%0d a=%0d b=%0d, want stage=%0d a=%0d b=%0d",
                     stage, op_a, op_b, m_stage, m_a, m_b);
        end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] vals [3] = '{4'd2, 4'd7, 4'd4};
        int go0;
        press(1, 0, 4'd12); model_enter(4'd12);
        press(1, 0, 4'd13); model_enter(4'd13);
        sw = 4'd15;
        btn_enter = 1'b1;
        tick(8);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            n_checks++;
            if ({stage, op_a, op_b, opcode, go} !== '0) begin
                n_fail++;
                $display("FAIL reset_mid_cycle%0d: got stage=%0d a=%0d b=%0d op=%0d go=%b, want all 0",
                         i, stage, op_a, op_b, opcode, go);
            end
        end
        rst_n = 1'b1;
        btn_enter = 1'b0;
        model_clear();
        go0 = go_pulses;
        tick(SETTLE);
        for (int i = 0; i < 3; i++) begin
            press(1, 0, vals[i]);
            model_enter(vals[i]);
            n_checks++;
            if ({stage, op_a, op_b, opcode} !== {m_stage[1:0], m_a, m_b, m_op}
                || go_pulses - go0 != (i == 2 ? 1 : 0)) begin
                n_fail++;
                $display("FAIL reset_mid_press%0d: got stage=%0d a=%0d b=%0d op=%0d go_new=%0d, want stage=%0d a=%0d b=%0d op=%0d go_new=%0d",
                         i, stage, op_a, op_b, opcode, go_pulses - go0,
                         m_stage, m_a, m_b, m_op, (i == 2 ? 1 : 0));
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] v;
        int r;
        for (int i = 0; i < 30; i++) begin
            v = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            r = $urandom_range(0, 9);
            if (r == 0) begin
                press(0, 1, v); model_clear();
            end else if (r == 1) begin
                sw = v;
                btn_enter = 1'b1; tick($urandom_range(1, DB - 2));
                btn_enter = 1'b0; tick(SETTLE);
            end else if (r == 2) begin
                press(1, 1, v); model_clear();
            end else begin
                press(1, 0, v); model_enter(v);
            end
            n_checks++;
            if ({stage, op_a, op_b, opcode} !== {m_stage[1:0], m_a, m_b, m_op}
                || go_pulses != m_go || go_cycles != m_go) begin
                n_fail++;
                $display("FAIL random_op%0d(kind %0d): got stage=%0d a=%0d b=%0d op=%0d go=%0d/%0d, want stage=%0d a=%0d b=%0d op=%0d go=%0d",
                         i, r, stage, op_a, op_b, opcode, go_pulses, go_cycles,
                         m_stage, m_a, m_b, m_op, m_go);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_latency();
        test_glitch();
        test_hold();
        test_clear();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
